sequence_counter: RTL and testbench

- Timing-state generator for the basic-computer controller.
- Holds a binary step count and decodes it into a one-hot timing vector T (T[0]=fetch step 0, T[1], ...).
- The controller advances it with INR during fetch and returns it to T0 with CLR at the end of each instruction.

---
 rtl/sc_pkg.sv | 9 +
 rtl/sequence_counter_if.sv | 19 +
 rtl/sc_decoder.sv | 9 +
 rtl/sequence_counter.sv | 32 +++
 tb/tb_sequence_counter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/sc_pkg.sv
// sc_pkg: shared widths and named fetch/decode steps for the sequence counter.
package sc_pkg;
    localparam int SC_CNT_W = 4;
    localparam int SC_T_W = 1 << SC_CNT_W;
    localparam logic [SC_CNT_W-1:0] SC_T0 = SC_CNT_W'(0);
    localparam logic [SC_CNT_W-1:0] SC_T1 = SC_CNT_W'(1);
    localparam logic [SC_CNT_W-1:0] SC_T2 = SC_CNT_W'(2);
    localparam logic [SC_CNT_W-1:0] SC_T3 = SC_CNT_W'(3);
endpackage

// File: rtl/sequence_counter_if.sv
// sequence_counter_if: controller <-> sequence counter bundle; WRAP exists only with SC_WRAP_FLAG_EN.
interface sequence_counter_if
    import sc_pkg::*;
#(
    parameter int CNT_W = SC_CNT_W
);
    logic CLR;
    logic INR;
    logic [2**CNT_W-1:0] T;
    logic [CNT_W-1:0] CNT;
`ifdef SC_WRAP_FLAG_EN
    logic WRAP;
    modport master(output CLR, output INR, input T, input CNT, input WRAP);
    modport slave(input CLR, input INR, output T, output CNT, output WRAP);
`else
    modport master(output CLR, output INR, input T, input CNT);
    modport slave(input CLR, input INR, output T, output CNT);
`endif
endinterface

// File: rtl/sc_decoder.sv
// sc_decoder: combinational CNT_W-to-2**CNT_W one-hot decoder.
module sc_decoder #(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0]    sel,
    output logic [2**CNT_W-1:0] onehot
);
    always_comb onehot = (2**CNT_W)'(1) << sel;
endmodule

// File: rtl/sequence_counter.sv
// sequence_counter: timing-state counter with one-hot T decode.
// Optional WRAP runaway flag enabled by defining SC_WRAP_FLAG_EN.
module sequence_counter
    import sc_pkg::*;
#(
    parameter int CNT_W = SC_CNT_W
) (
    input logic clk,
    input logic rst,
    sequence_counter_if.slave bus
);
    logic [CNT_W-1:0] cnt;
    // if() on an X control falls to the else branch, so unresolved CLR/INR act as 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (bus.CLR) cnt <= '0;
        else if (bus.INR) cnt <= cnt + 1'b1;
    end
`ifdef SC_WRAP_FLAG_EN
    logic wrap;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wrap <= 1'b0;
        else wrap <= !bus.CLR && bus.INR && (&cnt);
    end
    assign bus.WRAP = wrap;
`endif
    assign bus.CNT = cnt;
    sc_decoder #(.CNT_W(CNT_W)) u_dec (
        .sel   (cnt),
        .onehot(bus.T)
    );
endmodule

// File: tb/tb_sequence_counter.sv
// tb_sequence_counter: directed checks of reset, walk, hold/clear, priority, wrap and one-hot invariant.
module tb_sequence_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    sequence_counter_if #(.CNT_W(4)) bus ();
    sequence_counter #(.CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] exp_t, input logic [3:0] exp_cnt);
        checks++;
        if (bus.T !== exp_t) begin
            errors++;
            $display("FAIL %s: T=%h expected %h", name, bus.T, exp_t);
        end
        checks++;
        if (bus.CNT !== exp_cnt) begin
            errors++;
            $display("FAIL %s: CNT=%0d expected %0d", name, bus.CNT, exp_cnt);
        end
    endtask

    task automatic chk_wrap(input string name, input logic exp_w);
`ifdef SC_WRAP_FLAG_EN
        checks++;
        if (bus.WRAP !== exp_w) begin
            errors++;
            $display("FAIL %s: WRAP=%b expected %b", name, bus.WRAP, exp_w);
        end
`endif
    endtask

    task automatic test_reset();
        bus.CLR = 1'b0;
        bus.INR = 1'b0;
        #2;
        chk("reset_initial", 16'h0001, 4'd0);
        chk_wrap("reset_wrap", 1'b0);
        step();
        rst = 1'b0;
        bus.INR = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("pre_reset_cnt5", 16'h0020, 4'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_midcycle", 16'h0001, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_hold_inr", 16'h0001, 4'd0);
        end
    endtask

    task automatic test_fetch_walk();
        rst = 1'b0;
        bus.INR = 1'b1;
        chk("walk_t0", 16'h0001, 4'd0);
        step();
        chk("walk_t1", 16'h0002, 4'd1);
        step();
        chk("walk_t2", 16'h0004, 4'd2);
        step();
        chk("walk_t3", 16'h0008, 4'd3);
    endtask

    task automatic test_hold_clear();
        bus.INR = 1'b0;
        step();
        chk("hold1", 16'h0008, 4'd3);
        step();
        chk("hold2", 16'h0008, 4'd3);
        bus.CLR = 1'b1;
        step();
        chk("clear", 16'h0001, 4'd0);
        bus.CLR = 1'b0;
    endtask

    task automatic test_priority();
        bus.INR = 1'b1;
        step();
        step();
        chk("prio_setup", 16'h0004, 4'd2);
        bus.CLR = 1'b1;
        step();
        chk("prio_clr_over_inr", 16'h0001, 4'd0);
        bus.CLR = 1'b0;
        bus.INR = 1'b0;
    endtask

    task automatic test_wrap();
        bus.INR = 1'b1;
        for (int i = 1; i <= 15; i++) step();
        chk("wrap_t15", 16'h8000, 4'd15);
        chk_wrap("wrap_before", 1'b0);
        step();
        chk("wrap_to_t0", 16'h0001, 4'd0);
        chk_wrap("wrap_pulse", 1'b1);
        bus.INR = 1'b0;
        step();
        chk_wrap("wrap_one_cycle", 1'b0);
        bus.INR = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("clr_at_15_setup", 16'h8000, 4'd15);
        bus.CLR = 1'b1;
        step();
        chk("clr_at_15", 16'h0001, 4'd0);
        chk_wrap("clr_no_wrap", 1'b0);
        bus.CLR = 1'b0;
        bus.INR = 1'b0;
    endtask

    task automatic test_onehot();
        logic [3:0] m_cnt;
        logic m_wrap;
        logic c;
        logic n;
        m_cnt = bus.CNT === 4'd0 ? 4'd0 : 4'hx;
        m_wrap = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            c = ($urandom_range(0, 7) == 0);
            n = 1'($urandom_range(0, 1));
            bus.CLR = c;
            bus.INR = n;
            m_wrap = !c && n && (m_cnt == 4'd15);
            m_cnt = c ? 4'd0 : n ? m_cnt + 4'd1 : m_cnt;
            step();
            chk("random", 16'h0001 << m_cnt, m_cnt);
            chk_wrap("random_wrap", m_wrap);
            checks++;
            if (!$onehot(bus.T)) begin
                errors++;
                $display("FAIL onehot: T=%h expected exactly one bit set", bus.T);
            end
        end
        bus.CLR = 1'b0;
        bus.INR = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_walk();
        test_hold_clear();
        test_priority();
        test_wrap();
        test_onehot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
